// File: rtl/burst_rr_scheduler.sv
// Round-robin burst scheduler: one registered one-hot grant is held for a whole burst of req_len+1 beats.
// Optional feature: define BURST_RR_SCHED_ABORT_EN to add an abort input that ends the current burst early.
module burst_rr_scheduler #(
  parameter int CLIENTS = 8,
  parameter int LEN_W   = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [CLIENTS-1:0]       request,
  input  logic [CLIENTS*LEN_W-1:0] req_len,
  input  logic                     stall,
`ifdef BURST_RR_SCHED_ABORT_EN
  input  logic                     abort,
`endif
  output logic [CLIENTS-1:0]       grant,
  output logic                     busy,
  output logic                     last,
  output logic [LEN_W-1:0]         beats_left
);

  localparam int IDX_W = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CLIENTS-1:0] grant_q, grant_d;
  logic [LEN_W-1:0]   beats_q, beats_d;

  logic [IDX_W-1:0]   next_ptr;
  logic [IDX_W-1:0]   search_ptr;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;
  logic [LEN_W-1:0]   win_len;
  logic               found;
  logic               last_beat;
  logic               complete;
  int                 sum;

  assign last_beat = (state_q == BURST) && (beats_q == '0);

`ifdef BURST_RR_SCHED_ABORT_EN
  assign complete = (state_q == BURST) && ((last_beat && !stall) || abort);
`else
  assign complete = (state_q == BURST) && last_beat && !stall;
`endif

  // At completion the search starts just past the finishing client, making it lowest priority.
  assign next_ptr   = (idx_q == IDX_W'(CLIENTS - 1)) ? '0 : idx_q + 1'b1;
  assign search_ptr = (state_q == BURST) ? next_ptr : ptr_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    sum     = 0;
    for (int i = 0; i < CLIENTS; i++) begin
      sum = int'(search_ptr) + i;
      if (sum >= CLIENTS) sum = sum - CLIENTS;
      cand = IDX_W'(sum);
      if (!found && request[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign win_len = req_len[int'(win_idx)*LEN_W +: LEN_W];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    beats_d = beats_q;
    unique case (state_q)
      IDLE: begin
        if (found && !stall) begin
          state_d = BURST;
          idx_d   = win_idx;
          grant_d = CLIENTS'(1) << win_idx;
          beats_d = win_len;
        end
      end
      BURST: begin
        if (complete) begin
          ptr_d = next_ptr;
          if (found) begin
            idx_d   = win_idx;
            grant_d = CLIENTS'(1) << win_idx;
            beats_d = win_len;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            beats_d = '0;
          end
        end else if (!stall && beats_q != '0) begin
          beats_d = beats_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      grant_q <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      beats_q <= beats_d;
    end
  end

  assign grant      = grant_q;
  assign busy       = |grant_q;
  assign last       = last_beat;
  assign beats_left = beats_q;

endmodule

// File: tb/tb_burst_rr_scheduler.sv
// Directed testbench for burst_rr_scheduler (CLIENTS=8, LEN_W=4) with hand-computed expectations.
// Build with BURST_RR_SCHED_ABORT_EN defined to also exercise the abort scenario.
module tb_burst_rr_scheduler;

  localparam int CLIENTS = 8;
  localparam int LEN_W   = 4;

  logic                     clock = 1'b0;
  logic                     reset = 1'b0;
  logic [CLIENTS-1:0]       request = '0;
  logic [CLIENTS*LEN_W-1:0] req_len = '0;
  logic                     stall = 1'b0;
`ifdef BURST_RR_SCHED_ABORT_EN
  logic                     abort = 1'b0;
`endif
  logic [CLIENTS-1:0]       grant;
  logic                     busy;
  logic                     last;
  logic [LEN_W-1:0]         beats_left;

  int errors = 0;
  int checks = 0;

  burst_rr_scheduler #(.CLIENTS(CLIENTS), .LEN_W(LEN_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .request    (request),
    .req_len    (req_len),
    .stall      (stall),
`ifdef BURST_RR_SCHED_ABORT_EN
    .abort      (abort),
`endif
    .grant      (grant),
    .busy       (busy),
    .last       (last),
    .beats_left (beats_left)
  );

  always #5 clock = ~clock;

  // Advance one rising edge and settle; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_len(input int c, input int l);
    req_len[c*LEN_W +: LEN_W] = LEN_W'(l);
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    request = '0;
    req_len = '0;
    stall   = 1'b0;
`ifdef BURST_RR_SCHED_ABORT_EN
    abort   = 1'b0;
`endif
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (grant !== 8'h00 || busy !== 1'b0 || last !== 1'b0 || beats_left !== 4'd0) begin
      errors++;
      $display("FAIL reset_state grant=%h busy=%b last=%b beats=%0d expected 00/0/0/0", grant, busy, last, beats_left);
    end
  endtask

  task automatic test_single_burst();
    logic [7:0] exp_g [4] = '{8'h01, 8'h01, 8'h01, 8'h00};
    logic [3:0] exp_b [4] = '{4'd2, 4'd1, 4'd0, 4'd0};
    logic       exp_l [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    set_len(0, 2);
    request = 8'h01;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 0) request = 8'h00;  // deassertion mid-burst must be ignored
      checks++;
      if (grant !== exp_g[c] || beats_left !== exp_b[c] || last !== exp_l[c] || busy !== (exp_g[c] != 0)) begin
        errors++;
        $display("FAIL single_burst cycle %0d grant=%h beats=%0d last=%b busy=%b expected %h/%0d/%b", c + 1, grant, beats_left, last, busy, exp_g[c], exp_b[c], exp_l[c]);
      end
    end
  endtask

  task automatic test_idle_stall();
    do_reset();
    request = 8'h08;
    stall   = 1'b1;
    tick();
    tick();
    checks++;
    if (grant !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_stall grant=%h busy=%b expected 00/0", grant, busy);
    end
    stall = 1'b0;
    tick();
    checks++;
    if (grant !== 8'h08 || last !== 1'b1) begin
      errors++;
      $display("FAIL idle_release grant=%h last=%b expected 08/1", grant, last);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    do_reset();
    request = 8'h0A;
    for (int k = 0; k < 6; k++) begin
      tick();
      exp = (k % 2 == 0) ? 8'h02 : 8'h08;
      checks++;
      if (grant !== exp || last !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back cycle %0d grant=%h last=%b expected %h/1", k + 1, grant, last, exp);
      end
    end
  endtask

  task automatic test_stall();
    logic [3:0] exp_b [8] = '{4'd3, 4'd2, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd0};
    do_reset();
    set_len(5, 3);
    request = 8'h20;
    for (int c = 1; c <= 9; c++) begin
      tick();
      checks++;
      if (c <= 8) begin
        if (grant !== 8'h20 || beats_left !== exp_b[c-1] || last !== (c == 8)) begin
          errors++;
          $display("FAIL stall cycle %0d grant=%h beats=%0d last=%b expected 20/%0d/%b", c, grant, beats_left, last, exp_b[c-1], (c == 8));
        end
      end else if (grant !== 8'h00 || busy !== 1'b0) begin
        errors++;
        $display("FAIL stall_end grant=%h busy=%b expected 00/0", grant, busy);
      end
      if (c == 1) request = 8'h00;
      stall = (c >= 3 && c <= 6);
    end
  endtask

  task automatic test_rotate();
    logic [7:0] exp;
    do_reset();
    request = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      exp = 8'h01 << (k % 8);
      checks++;
      if (grant !== exp) begin
        errors++;
        $display("FAIL rotate step %0d grant=%h expected %h", k, grant, exp);
      end
    end
  endtask

  task automatic test_max_len();
    do_reset();
    set_len(0, 15);
    request = 8'h01;
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (c == 1) begin
        set_len(0, 0);  // length change after latching must be ignored
        request = 8'h00;
      end
      checks++;
      if (c <= 16) begin
        if (grant !== 8'h01 || beats_left !== 4'(16 - c) || last !== (c == 16)) begin
          errors++;
          $display("FAIL max_len beat %0d grant=%h beats=%0d last=%b expected 01/%0d/%b", c, grant, beats_left, last, 16 - c, (c == 16));
        end
      end else if (grant !== 8'h00) begin
        errors++;
        $display("FAIL max_len_end grant=%h expected 00", grant);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    request = 8'h04;
    tick();
    request = 8'h24;
    set_len(5, 3);
    tick();
    checks++;
    if (grant !== 8'h20 || beats_left !== 4'd3) begin
      errors++;
      $display("FAIL rotate_to_5 grant=%h beats=%0d expected 20/3", grant, beats_left);
    end
    tick();
    checks++;
    if (beats_left !== 4'd2) begin
      errors++;
      $display("FAIL pre_reset beats=%0d expected 2", beats_left);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (grant !== 8'h00 || busy !== 1'b0 || last !== 1'b0 || beats_left !== 4'd0) begin
      errors++;
      $display("FAIL async_reset grant=%h busy=%b last=%b beats=%0d expected 00/0/0/0", grant, busy, last, beats_left);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    tick();
    checks++;
    if (grant !== 8'h04) begin
      errors++;
      $display("FAIL post_reset_grant grant=%h expected 04", grant);
    end
  endtask

`ifdef BURST_RR_SCHED_ABORT_EN
  task automatic test_abort();
    do_reset();
    set_len(2, 15);
    request = 8'h14;
    tick();
    checks++;
    if (grant !== 8'h04 || beats_left !== 4'd15) begin
      errors++;
      $display("FAIL abort_setup grant=%h beats=%0d expected 04/15", grant, beats_left);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (grant !== 8'h10 || beats_left !== 4'd0) begin
      errors++;
      $display("FAIL abort grant=%h beats=%0d expected 10/0", grant, beats_left);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_burst();
    test_idle_stall();
    test_back_to_back();
    test_stall();
    test_rotate();
    test_max_len();
    test_reset_mid_burst();
`ifdef BURST_RR_SCHED_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
